// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Define MULDIV_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise they decode as no-ops.
module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        is_mul, is_div, is_mac, launch, commit;
    logic        div_r, mul_sgn, a_neg, b_neg;
    logic [31:0] mag_a, mag_b, q_u, r_u, quo, rem;
    logic [63:0] prod, res;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_MADD_EN
    assign is_mac = (op[2:1] == 2'b11);
`else
    assign is_mac = 1'b0;
`endif
    assign launch = (state == IDLE) && start && (is_mul || is_div || is_mac);
    assign commit = (state == RUN) && (cnt == 5'd1);
    assign busy   = (state == RUN);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (launch) begin
            state_nx = RUN;
            cnt_nx   = is_div ? DIV_CYCLES[4:0] : MUL_CYCLES[4:0];
        end else if (state == RUN) begin
            state_nx = commit ? IDLE : RUN;
            cnt_nx   = commit ? 5'd0 : cnt - 5'd1;
        end
    end

    // Signed ops (MULT, MADD) have op[0]==0; sign-extend to 64 bits so a plain multiply wraps correctly.
    assign mul_sgn = ~op_r[0];
    assign prod    = {{32{mul_sgn & a_r[31]}}, a_r} * {{32{mul_sgn & b_r[31]}}, b_r};

    // Signed divide works on magnitudes; quotient truncates toward zero, remainder follows the dividend.
    assign div_r = (op_r == OP_DIV) || (op_r == OP_DIVU);
    assign a_neg = (op_r == OP_DIV) & a_r[31];
    assign b_neg = (op_r == OP_DIV) & b_r[31];
    assign mag_a = a_neg ? -a_r : a_r;
    assign mag_b = b_neg ? -b_r : b_r;
    assign q_u   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign r_u   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign quo   = (a_neg ^ b_neg) ? -q_u : q_u;
    assign rem   = a_neg ? -r_u : r_u;

    always_comb begin
`ifdef MULDIV_MADD_EN
        res = div_r ? ((b_r == 32'd0) ? {hi, lo} : {rem, quo})
                    : (op_r[2:1] == 2'b11) ? {hi, lo} + prod : prod;
`else
        res = div_r ? ((b_r == 32'd0) ? {hi, lo} : {rem, quo}) : prod;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            op_r  <= 3'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (launch) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
            end
            if (commit) begin
                {hi, lo} <= res;
            end else if ((state == IDLE) && start) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand sequences for muldiv_unit.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;
    int          tests = 0;
    int          fails = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          exp_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns the number of busy cycles observed.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int bc);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int bc;
        vecs[0]  = '{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'd3,        32'd0,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'd0,        32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{"div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2,        32'd0,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{"divu_by0",   3'd3, 32'd7,        32'd0,        32'h11, 32'h22,       32'h11,       32'h22,       10};
        vecs[4]  = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,        32'd0,        32'h80000000, 10};
        vecs[5]  = '{"divu_100_7", 3'd3, 32'd100,      32'd7,        32'd0,  32'd0,        32'd2,        32'd14,       10};
        vecs[6]  = '{"div_7_neg2", 3'd2, 32'd7,        32'hFFFFFFFE, 32'd0,  32'd0,        32'd1,        32'hFFFFFFFD, 10};
        vecs[7]  = '{"mult_min2",  3'd0, 32'h80000000, 32'h80000000, 32'd0,  32'd0,        32'h40000000, 32'd0,        5};
        vecs[8]  = '{"multu_2p32", 3'd1, 32'h00010000, 32'h00010000, 32'd0,  32'd0,        32'd1,        32'd0,        5};
        vecs[9]  = '{"div_n8_n3",  3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd0,  32'd0,        32'hFFFFFFFE, 32'd2,        10};
        vecs[12] = '{"div_by0",    3'd2, 32'hFFFFFFF0, 32'd0,        32'hAA, 32'hBB,       32'hAA,       32'hBB,       10};
`ifdef MULDIV_MADD_EN
        vecs[10] = '{"maddu",      3'd7, 32'd1,        32'd1,        32'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        5};
        vecs[11] = '{"madd",       3'd6, 32'hFFFFFFFF, 32'd2,        32'd0,  32'd5,        32'd0,        32'd3,        5};
`else
        vecs[10] = '{"maddu_nop",  3'd7, 32'd1,        32'd1,        32'd0,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 0};
        vecs[11] = '{"madd_nop",   3'd6, 32'hFFFFFFFF, 32'd2,        32'd0,  32'd5,        32'd0,        32'd5,        0};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_op(3'd4, vecs[i].pre_hi, 32'd0, bc);
            do_op(3'd5, vecs[i].pre_lo, 32'd0, bc);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
            chk({vecs[i].name, "_busy"}, 64'(bc), 64'(vecs[i].exp_busy));
            chk({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].exp_hi});
            chk({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].exp_lo});
        end

        // MTHI in IDLE: single cycle, no busy
        do_op(3'd4, 32'h1234, 32'd0, bc);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        chk("mthi_busy", 64'(bc), 64'd0);
        do_op(3'd5, 32'd0, 32'd0, bc);

        // MTLO during MULT ignored, MULT in commit cycle ignored, hi/lo held during run
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; a = 32'h5555; b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_mtlo_ignored", {hi, lo}, {32'h1234, 32'd0});
        repeat (3) @(posedge clk);
        #1;
        chk("commit_cyc_busy", {63'd0, busy}, 64'd1);
        chk("run_hold", {hi, lo}, {32'h1234, 32'd0});
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk("commit_busy_low", {63'd0, busy}, 64'd0);
        chk("mult_6x7", {hi, lo}, 64'd42);
        repeat (3) @(posedge clk);
        #1;
        chk("commit_start_ignored", {63'd0, busy, hi, lo}, {63'd0, 1'b0, 64'd42});

        // async reset mid-DIV
        do_op(3'd4, 32'hAAAA, 32'd0, bc);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(3'd0, 32'd6, 32'd7, bc);
        chk("post_rst_busy", 64'(bc), 64'd5);
        chk("post_rst_mult", {hi, lo}, 64'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
